// File: rtl/iopmp_cfg_loader_pkg.sv
// State and error-code types for the IOPMP configuration loader.
// Readback states exist only when IOPMP_CFG_LOADER_READBACK_EN is defined.
package iopmp_cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
`ifdef IOPMP_CFG_LOADER_READBACK_EN
        ST_RB_REQ,
        ST_RB_RSP,
`endif
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } cfg_loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_DERR        = 2'd1,
        ERR_TIMEOUT     = 2'd2,
        ERR_RB_MISMATCH = 2'd3
    } cfg_err_code_e;

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL type set for the IOPMP register port: 34-bit byte address, 32-bit data bus.
package tlul_pkg;

    localparam int unsigned TL_AW  = 34;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DBW = TL_DW / 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/iopmp_cfg_loader_timer.sv
// Per-phase watchdog: cleared on phase entry, counts while enabled, flags TIMEOUT_CYCLES-1.
module iopmp_cfg_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/iopmp_cfg_loader.sv
// TL-UL master that replays a table of register writes into the IOPMP control port.
// Define IOPMP_CFG_LOADER_READBACK_EN to verify every write with a Get readback.
module iopmp_cfg_loader
    import tlul_pkg::*;
    import iopmp_cfg_loader_pkg::*;
#(
    parameter int unsigned       NUM_WRITES     = 8,
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [TL_AIW-1:0] SOURCE_ID      = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [NUM_WRITES-1:0][TL_AW-1:0]    cfg_addr_i,
    input  logic [NUM_WRITES-1:0][TL_DW-1:0]    cfg_data_i,
    output tl_h2d_t                             reg_prog_o,
    input  tl_d2h_t                             reg_prog_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o,
    output logic [$clog2(NUM_WRITES):0]         err_idx_o,
    output logic [1:0]                          err_code_o
);

    localparam int unsigned IDXW = $clog2(NUM_WRITES) + 1;
    localparam int unsigned SELW = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;

    cfg_loader_state_e r_state;
    cfg_err_code_e     r_fail;
    cfg_err_code_e     r_err_code;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   r_err_idx;
    logic              r_a_valid;
    tl_a_op_e          r_a_opcode;
    logic [TL_AW-1:0]  r_a_address;
    logic [TL_DW-1:0]  r_a_data;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [IDXW-1:0]   w_idx_inc;
    logic [SELW-1:0]   w_sel;
    logic [SELW-1:0]   w_inc_sel;
    logic              w_last;
    logic              w_a_hs;
    logic              w_d_hit;
    logic              w_timed;
    logic              w_adv;
    logic              w_expire;
    logic              w_unused;

    assign w_idx_inc = r_idx + 1'b1;
    assign w_sel     = r_idx[SELW-1:0];
    assign w_inc_sel = w_idx_inc[SELW-1:0];
    assign w_last    = (r_idx == IDXW'(NUM_WRITES - 1));
    assign w_a_hs    = r_a_valid && reg_prog_i.a_ready;
    assign w_d_hit   = reg_prog_i.d_valid && (reg_prog_i.d_source == SOURCE_ID);
    assign w_unused  = ^{reg_prog_i.d_param, reg_prog_i.d_size, reg_prog_i.d_sink,
                         reg_prog_i.d_opcode, reg_prog_i.d_data};

    // Timer restarts whenever the FSM is outside a waiting phase or its awaited handshake lands.
    always_comb begin
        w_timed = 1'b0;
        w_adv   = 1'b0;
        case (r_state)
            ST_REQ:    begin w_timed = 1'b1; w_adv = w_a_hs;  end
            ST_RSP:    begin w_timed = 1'b1; w_adv = w_d_hit; end
`ifdef IOPMP_CFG_LOADER_READBACK_EN
            ST_RB_REQ: begin w_timed = 1'b1; w_adv = w_a_hs;  end
            ST_RB_RSP: begin
                w_timed = 1'b1;
                w_adv   = w_d_hit && (reg_prog_i.d_opcode == AccessAckData);
            end
`endif
            default:   ;
        endcase
    end

    iopmp_cfg_loader_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_timed || w_adv),
        .i_en     (w_timed),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fail      <= ERR_NONE;
            r_err_code  <= ERR_NONE;
            r_idx       <= '0;
            r_err_idx   <= '0;
            r_a_valid   <= 1'b0;
            r_a_opcode  <= PutFullData;
            r_a_address <= '0;
            r_a_data    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_done      <= 1'b0;
                        r_err       <= 1'b0;
                        r_err_code  <= ERR_NONE;
                        r_err_idx   <= '0;
                        r_fail      <= ERR_NONE;
                        r_idx       <= '0;
                        r_busy      <= 1'b1;
                        r_a_valid   <= 1'b1;
                        r_a_opcode  <= PutFullData;
                        r_a_address <= cfg_addr_i[0];
                        r_a_data    <= cfg_data_i[0];
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_a_hs) begin
                        r_a_valid <= 1'b0;
                        r_state   <= ST_RSP;
                    end else if (w_expire) begin
                        r_a_valid <= 1'b0;
                        r_fail    <= ERR_TIMEOUT;
                        r_state   <= ST_ERR;
                    end
                end
                ST_RSP: begin
                    if (w_d_hit) begin
                        if (reg_prog_i.d_error) begin
                            r_fail  <= ERR_DERR;
                            r_state <= ST_ERR;
                        end else begin
`ifdef IOPMP_CFG_LOADER_READBACK_EN
                            r_a_valid  <= 1'b1;
                            r_a_opcode <= Get;
                            r_state    <= ST_RB_REQ;
`else
                            r_state    <= ST_NEXT;
`endif
                        end
                    end else if (w_expire) begin
                        r_fail  <= ERR_TIMEOUT;
                        r_state <= ST_ERR;
                    end
                end
`ifdef IOPMP_CFG_LOADER_READBACK_EN
                ST_RB_REQ: begin
                    if (w_a_hs) begin
                        r_a_valid <= 1'b0;
                        r_state   <= ST_RB_RSP;
                    end else if (w_expire) begin
                        r_a_valid <= 1'b0;
                        r_fail    <= ERR_TIMEOUT;
                        r_state   <= ST_ERR;
                    end
                end
                ST_RB_RSP: begin
                    if (w_adv) begin
                        if (reg_prog_i.d_error) begin
                            r_fail  <= ERR_DERR;
                            r_state <= ST_ERR;
                        end else if (reg_prog_i.d_data != cfg_data_i[w_sel]) begin
                            r_fail  <= ERR_RB_MISMATCH;
                            r_state <= ST_ERR;
                        end else begin
                            r_state <= ST_NEXT;
                        end
                    end else if (w_expire) begin
                        r_fail  <= ERR_TIMEOUT;
                        r_state <= ST_ERR;
                    end
                end
`endif
                ST_NEXT: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx       <= w_idx_inc;
                        r_a_valid   <= 1'b1;
                        r_a_opcode  <= PutFullData;
                        r_a_address <= cfg_addr_i[w_inc_sel];
                        r_a_data    <= cfg_data_i[w_inc_sel];
                        r_state     <= ST_REQ;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_err      <= 1'b1;
                    r_err_idx  <= r_idx;
                    r_err_code <= r_fail;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_prog_o           = '0;
        reg_prog_o.a_valid   = r_a_valid;
        reg_prog_o.a_opcode  = r_a_opcode;
        reg_prog_o.a_size    = 2'd2;
        reg_prog_o.a_source  = SOURCE_ID;
        reg_prog_o.a_address = r_a_address;
        reg_prog_o.a_mask    = '1;
        reg_prog_o.a_data    = r_a_data;
        reg_prog_o.d_ready   = 1'b1;
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign err_idx_o  = r_err_idx;
    assign err_code_o = r_err_code;

endmodule

// File: tb/tb_iopmp_cfg_loader.sv
// Randomised bench for iopmp_cfg_loader: a TL-UL slave with per-transaction delays/errors
// and a transaction-level model predicting outcome, completion cycle and request stream.
module tb_iopmp_cfg_loader;
    import tlul_pkg::*;

    localparam int unsigned NW    = 3;
    localparam int unsigned TO    = 16;
    localparam logic [7:0]  SRC   = 8'h05;
    localparam int unsigned NEVER = 1000;
`ifdef IOPMP_CFG_LOADER_READBACK_EN
    localparam int unsigned TPE   = 2;
`else
    localparam int unsigned TPE   = 1;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [33:0] addr;
        logic [31:0] data;
    } req_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_i;
    logic [NW-1:0][33:0]    cfg_addr;
    logic [NW-1:0][31:0]    cfg_data;
    tl_h2d_t                h2d;
    tl_d2h_t                d2h;
    logic                   busy, done, err;
    logic [2:0]             err_idx;
    logic [1:0]             err_code;

    always #5 clk = ~clk;

    iopmp_cfg_loader #(
        .NUM_WRITES     (NW),
        .TIMEOUT_CYCLES (TO),
        .SOURCE_ID      (SRC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .reg_prog_o (h2d),
        .reg_prog_i (d2h),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_idx_o  (err_idx),
        .err_code_o (err_code)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-transaction slave behaviour (transaction t = entry*TPE + phase)
    int unsigned adly [8];
    int unsigned rdly [8];
    bit          derr [8];
    bit          corrupt [8];
    bit          decoy_en, stray_en;

    // Slave bookkeeping
    int unsigned tcur, wcnt, rcnt, pend_t, stab_err, bad_fields;
    bit          pend, pend_get;
    logic [33:0] pend_addr;
    logic [68:0] snap;
    logic [31:0] mem [logic [33:0]];
    req_t        log_q [$];

    task automatic slave_reset();
        pend = 0; pend_get = 0; tcur = 0; wcnt = 0; rcnt = 0; pend_t = 0;
        stab_err = 0; bad_fields = 0;
        log_q.delete();
        mem.delete();
    endtask

    initial begin
        d2h = '0;
        slave_reset();
        forever begin
            @(posedge clk);
            #1;
            d2h = '0;
            if (pend) begin
                if (rcnt == rdly[pend_t]) begin
                    d2h.d_valid  = 1'b1;
                    d2h.d_source = SRC;
                    d2h.d_error  = derr[pend_t];
                    if (pend_get) begin
                        d2h.d_opcode = AccessAckData;
                        d2h.d_data   = (mem.exists(pend_addr) ? mem[pend_addr] : 32'h0)
                                       ^ {31'h0, corrupt[pend_t]};
                    end else begin
                        d2h.d_opcode = AccessAck;
                    end
                    pend = 0;
                end else begin
                    rcnt++;
                end
            end
            if (!d2h.d_valid && stray_en && $urandom_range(3) == 0) begin
                d2h.d_valid  = 1'b1;
                d2h.d_source = SRC ^ 8'h01;
                d2h.d_error  = 1'b1;
                d2h.d_opcode = AccessAckData;
                d2h.d_data   = $urandom;
            end
            if (h2d.a_valid && !pend) begin
                if (wcnt == 0) snap = {h2d.a_opcode, h2d.a_address, h2d.a_data};
                else if ({h2d.a_opcode, h2d.a_address, h2d.a_data} != snap) stab_err++;
                if (h2d.a_size != 2'd2 || h2d.a_mask != 4'hF || h2d.a_source != SRC
                    || h2d.a_param != 3'd0 || !h2d.d_ready) bad_fields++;
                if (wcnt == adly[tcur]) begin
                    d2h.a_ready = 1'b1;
                    log_q.push_back('{op: h2d.a_opcode, addr: h2d.a_address, data: h2d.a_data});
                    pend_get  = (h2d.a_opcode == Get);
                    pend_addr = h2d.a_address;
                    if (h2d.a_opcode == PutFullData) mem[h2d.a_address] = h2d.a_data;
                    if (decoy_en && !d2h.d_valid) begin
                        d2h.d_valid  = 1'b1;
                        d2h.d_source = SRC;
                        d2h.d_error  = 1'b1;
                    end
                    pend   = 1;
                    rcnt   = 0;
                    pend_t = tcur;
                    if (tcur < 7) tcur++;
                    wcnt   = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Transaction-level prediction: flag cycle (start sampled at end of cycle 0), outcome, #requests
    task automatic model(output int unsigned cyc, output logic exp_done,
                         output logic [1:0] code, output int unsigned idx,
                         output int unsigned nreq);
        int unsigned t;
        cyc = 1; code = 2'd0; idx = 0; nreq = 0;
        for (int unsigned e = 0; e < NW && code == 2'd0; e++) begin
            for (int unsigned p = 0; p < TPE && code == 2'd0; p++) begin
                t = e * TPE + p;
                if (adly[t] >= TO) begin
                    cyc += TO;
                    code = 2'd2;
                end else begin
                    cyc += adly[t] + 1;
                    nreq++;
                    if (rdly[t] >= TO) begin
                        cyc += TO;
                        code = 2'd2;
                    end else begin
                        cyc += rdly[t] + 1;
                        if (derr[t]) code = 2'd1;
                        else if (p == 1 && corrupt[t]) code = 2'd3;
                    end
                end
                if (code != 2'd0) idx = e;
            end
            if (code == 2'd0) cyc += 1;
        end
        exp_done = (code == 2'd0);
        cyc += 1;
    endtask

    function automatic int unsigned pick_dly(bit allow_never);
        int unsigned r;
        r = $urandom_range(19);
        if (r < 14) return $urandom_range(3);
        if (r < 17) return TO - 1;
        if (r < 19 || !allow_never) return TO;
        return NEVER;
    endfunction

    task automatic set_zero();
        for (int unsigned t = 0; t < 8; t++) begin
            adly[t] = 0; rdly[t] = 0; derr[t] = 0; corrupt[t] = 0;
        end
        decoy_en = 0; stray_en = 0;
        for (int unsigned e = 0; e < NW; e++) begin
            cfg_addr[e] = {2'($urandom_range(3)), $urandom};
            cfg_data[e] = $urandom;
        end
    endtask

    task automatic run_case(input int unsigned r, input bit dbl_start);
        int unsigned cyc, nreq, idx, k, e;
        logic        exp_done;
        logic [1:0]  code;
        string       pfx;
        pfx = $sformatf("run%0d", r);
        model(cyc, exp_done, code, idx, nreq);
        @(negedge clk);
        slave_reset();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 1;
        check({pfx, " busy_at_first_req"}, 64'(busy), 64'd1);
        while (!(done || err) && k < 2000) begin
            start_i = (dbl_start && k == 2);
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        check({pfx, " flag_cycle"}, 64'(k), 64'(cyc));
        check({pfx, " done"}, 64'(done), 64'(exp_done));
        check({pfx, " err"}, 64'(err), 64'(!exp_done));
        check({pfx, " err_code"}, 64'(err_code), 64'(code));
        check({pfx, " err_idx"}, 64'(err_idx), 64'(idx));
        check({pfx, " busy_end"}, 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check({pfx, " req_count"}, 64'(log_q.size()), 64'(nreq));
        for (int unsigned i = 0; i < nreq && i < log_q.size(); i++) begin
            e = i / TPE;
            check($sformatf("%s req%0d op_addr", pfx, i), 64'({log_q[i].op, log_q[i].addr}),
                  64'({(i % TPE == 1) ? 3'h4 : 3'h0, cfg_addr[e]}));
            if (i % TPE == 0)
                check($sformatf("%s req%0d data", pfx, i), 64'(log_q[i].data), 64'(cfg_data[e]));
        end
        check({pfx, " a_stable"}, 64'(stab_err), 64'd0);
        check({pfx, " a_fields"}, 64'(bad_fields), 64'd0);
    endtask

    task automatic reset_test();
        int unsigned k;
        set_zero();
        rdly[TPE] = 4;
        @(negedge clk);
        slave_reset();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        k = 0;
        while (log_q.size() < TPE + 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid reached_entry1", 64'(log_q.size()), 64'(TPE + 1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid done", 64'(done), 64'd0);
        check("rst_mid err", 64'(err), 64'd0);
        check("rst_mid a_valid", 64'(h2d.a_valid), 64'd0);
        check("rst_mid err_code", 64'(err_code), 64'd0);
        set_zero();
        run_case(100, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        set_zero();
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset a_valid", 64'(h2d.a_valid), 64'd0);
        check("reset d_ready", 64'(h2d.d_ready), 64'd1);
        check("reset err_idx", 64'(err_idx), 64'd0);
        check("reset err_code", 64'(err_code), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int unsigned r = 0; r < 45; r++) begin
            set_zero();
            case (r)
                0: ;
                1: adly[TPE] = 5;
                2: derr[2 * TPE] = 1;
                3: rdly[0] = NEVER;
                4: corrupt[1] = 1;
                5: begin adly[0] = TO - 1; rdly[0] = TO - 1; end
                6: adly[TPE] = TO;
                default: begin
                    for (int unsigned t = 0; t < NW * TPE; t++) begin
                        adly[t]    = pick_dly(1'b0);
                        rdly[t]    = pick_dly(1'b1);
                        derr[t]    = ($urandom_range(11) == 0);
                        corrupt[t] = (t % 2 == 1) && ($urandom_range(5) == 0);
                    end
                    decoy_en = $urandom_range(1) == 1;
                    stray_en = $urandom_range(1) == 1;
                end
            endcase
            run_case(r, (r % 2) == 1);
        end
        reset_test();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
